uart_rx_parity: RTL and testbench

UART_RX_PARITY -- requirements
Module: uart_rx_parity

---
 rtl/uart_pkg.sv | 22 ++
 rtl/baud_timer.sv | 39 +++
 rtl/uart_rx_parity.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_parity.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the parity UART receiver.
//   rx_state_t  : receiver FSM state encoding
//   parity_err  : parity check of a data byte plus received parity bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } rx_state_t;

  // Even (odd = 0): error when data + parity hold an odd number of ones.
  // Odd  (odd = 1): error when data + parity hold an even number of ones.
  function automatic logic parity_err(input logic [7:0] data,
                                      input logic       par_bit,
                                      input logic       odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/baud_timer.sv
// Bit-period timer for the UART receiver.
//   clk, rst : system clock, async active-high reset
//   clear    : force the count to 0 (takes priority)
//   count    : advance the timer this cycle
//   half_tc  : count has reached HALF_BIT-1 (middle of the start bit)
//   full_tc  : count has reached CLKS_PER_BIT-1; the timer wraps to 0 here
module baud_timer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic half_tc,
  output logic full_tc
);

  localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] FULL_LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_LAST = W'((HALF_BIT > 0) ? HALF_BIT - 1 : 0);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      if (cnt == FULL_LAST) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
    end
  end

  assign half_tc = (cnt == HALF_LAST);
  assign full_tc = (cnt == FULL_LAST);

endmodule

// File: rtl/uart_rx_parity.sv
// 8-bit UART receiver with one parity bit and one stop bit (8E1 / 8O1).
//   clk          : system clock
//   rst          : async active-high reset
//   rx_in        : asynchronous serial line, idle high
//   dout         : last received data byte
//   data_strobe  : one-cycle pulse when dout and the error flags update
//   rx_busy      : high while a frame is in progress
//   parity_error : parity result of the last frame
//   frame_error  : last frame's stop bit was sampled low
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | counting to the middle of the start bit to confirm it
// DATA  | sampling 8 data bits, LSB first, one per bit period
// PAR   | sampling the parity bit
// STOP  | sampling the stop bit, then publishing the frame
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int PARITY        = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] dout,
  output logic       data_strobe,
  output logic       rx_busy,
  output logic       parity_error,
  output logic       frame_error
);

  localparam int   CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
  localparam int   HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic ODD_PARITY   = (PARITY != 0);

  rx_state_t   state, state_nxt;
  logic [1:0]  sync_q;
  logic        rx_s;
  logic        rx_prev;
  logic        fall;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx;
  logic        par_q;

  logic        timer_clr;
  logic        half_tc;
  logic        full_tc;
  logic        take_data;
  logic        take_par;
  logic        take_stop;

  // Synchronizer and edge history reset to the idle level so that reset
  // release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rx_in};
      rx_prev <= sync_q[1];
    end
  end

  assign rx_s = sync_q[1];
  // Requiring a 1 in the previous cycle keeps a held-low break line from
  // starting frames; rx_prev runs every cycle, so an edge landing on the
  // cycle IDLE is re-entered is still seen.
  assign fall = rx_prev & ~rx_s;

  baud_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .HALF_BIT     (HALF_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clr),
    .count   (state != IDLE),
    .half_tc (half_tc),
    .full_tc (full_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    take_data = 1'b0;
    take_par  = 1'b0;
    take_stop = 1'b0;
    unique case (state)
      IDLE: begin
        timer_clr = 1'b1;
        if (fall) state_nxt = START;
      end
      START: begin
        if (half_tc) begin
          if (!rx_s) begin
            state_nxt = DATA;
            timer_clr = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (full_tc) begin
          take_data = 1'b1;
          if (bit_idx == 3'd7) state_nxt = PAR;
        end
      end
      PAR: begin
        if (full_tc) begin
          take_par  = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (full_tc) begin
          take_stop = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q      <= 8'h00;
      bit_idx      <= 3'd0;
      par_q        <= 1'b0;
      dout         <= 8'h00;
      data_strobe  <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      data_strobe <= 1'b0;
      if (state == IDLE) bit_idx <= 3'd0;
      if (take_data) begin
        shift_q <= {rx_s, shift_q[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (take_par) par_q <= rx_s;
      if (take_stop) begin
        dout         <= shift_q;
        parity_error <= parity_err(shift_q, par_q, ODD_PARITY);
        frame_error  <= ~rx_s;
        data_strobe  <= 1'b1;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_parity.sv
`timescale 1ns/1ps
module tb_uart_rx_parity;

  localparam int BIT_NS = 8680;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  logic [7:0] dout_e, dout_o;
  logic       stb_e, stb_o, busy_e, busy_o, pe_e, pe_o, fe_e, fe_o;

  uart_rx_parity #(.PARITY(0)) u_even (
    .clk(clk), .rst(rst), .rx_in(rx), .dout(dout_e), .data_strobe(stb_e),
    .rx_busy(busy_e), .parity_error(pe_e), .frame_error(fe_e)
  );

  uart_rx_parity #(.PARITY(1)) u_odd (
    .clk(clk), .rst(rst), .rx_in(rx), .dout(dout_o), .data_strobe(stb_o),
    .rx_busy(busy_o), .parity_error(pe_o), .frame_error(fe_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         gap;
    logic       pe_even;
    logic       pe_odd;
    logic       fe;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q_even[$];
  exp_t q_odd[$];
  vec_t vecs[5];

  int tests = 0;
  int fails = 0;
  int n_stb_e = 0;
  int n_stb_o = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (stb_e) begin
      n_stb_e++;
      if (q_even.size() == 0) begin
        check("even_unexpected_strobe", 1, 0);
      end else begin
        e = q_even.pop_front();
        check("even_dout", {24'h0, dout_e}, {24'h0, e.d});
        check("even_parity_error", {31'h0, pe_e}, {31'h0, e.pe});
        check("even_frame_error", {31'h0, fe_e}, {31'h0, e.fe});
      end
    end
    if (stb_o) begin
      n_stb_o++;
      if (q_odd.size() == 0) begin
        check("odd_unexpected_strobe", 1, 0);
      end else begin
        e = q_odd.pop_front();
        check("odd_dout", {24'h0, dout_o}, {24'h0, e.d});
        check("odd_parity_error", {31'h0, pe_o}, {31'h0, e.pe});
        check("odd_frame_error", {31'h0, fe_o}, {31'h0, e.fe});
      end
    end
  end

  task automatic push_exp(input logic [7:0] d, input logic pe_even,
                          input logic pe_odd, input logic fe);
    exp_t e;
    e.d = d; e.fe = fe;
    e.pe = pe_even; q_even.push_back(e);
    e.pe = pe_odd;  q_odd.push_back(e);
  endtask

  // Leaves the line at the stop-bit level; the caller decides what follows.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    rx = 1'b0; #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i]; #(BIT_NS);
    end
    rx = p; #(BIT_NS);
    rx = s; #(BIT_NS);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q_even.size() + q_odd.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, q_even.size() + q_odd.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_dout_e"}, {24'h0, dout_e}, 0);
    check({tag, "_dout_o"}, {24'h0, dout_o}, 0);
    check({tag, "_strobe"}, {30'h0, stb_e, stb_o}, 0);
    check({tag, "_busy"}, {30'h0, busy_e, busy_o}, 0);
    check({tag, "_parity_error"}, {30'h0, pe_e, pe_o}, 0);
    check({tag, "_frame_error"}, {30'h0, fe_e, fe_o}, 0);
  endtask

  initial begin
    int   seen;
    int   s_before;
    logic [7:0] d_before;

    //          data   par   stop  gap pe_e  pe_o  fe
    vecs[0] = '{8'h5A, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h5A, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h12, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hED, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(posedge clk);
    check_reset_outputs("reset");
    #2 rst = 1'b0;
    #(BIT_NS);

    // Frames 3 and 4 run back to back with a single stop bit between them.
    for (int i = 0; i < 5; i++) begin
      push_exp(vecs[i].data, vecs[i].pe_even, vecs[i].pe_odd, vecs[i].fe);
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
      rx = 1'b1;
      #(vecs[i].gap * BIT_NS);
    end
    wait_drain("table_drain");
    check("table_strobe_count", n_stb_e, 5);

    // Stop bit low then the line held low (break): one strobe only.
    push_exp(8'h41, 1'b0, 1'b1, 1'b1);
    send_frame(8'h41, 1'b0, 1'b0);
    #(2 * BIT_NS);
    rx = 1'b1;
    #(BIT_NS);
    wait_drain("break_drain");
    check("break_strobe_count", n_stb_e, 6);

    // 200 ns glitch: busy must pulse, no strobe, dout unchanged.
    s_before = n_stb_e;
    d_before = dout_e;
    seen = 0;
    rx = 1'b0;
    #200;
    rx = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy_e) seen = 1;
    end
    check("glitch_busy_seen", seen, 1);
    repeat (600) @(negedge clk);
    check("glitch_busy_cleared", {31'h0, busy_e}, 0);
    check("glitch_no_strobe", n_stb_e, s_before);
    check("glitch_dout_kept", {24'h0, dout_e}, {24'h0, d_before});

    // Reset in the middle of data bit 4 of 0x77.
    s_before = n_stb_e;
    rx = 1'b0; #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 3) ? 1'b0 : 1'b1; #(BIT_NS);
    end
    rx = 1'b1;
    #(BIT_NS / 2);
    check("midframe_busy", {31'h0, busy_e}, 1);
    rst = 1'b1;
    #100;
    check_reset_outputs("midframe_reset");
    #2 rst = 1'b0;
    #(2 * BIT_NS);
    check("midframe_no_strobe", n_stb_e, s_before);
    push_exp(8'h33, 1'b0, 1'b1, 1'b0);
    send_frame(8'h33, 1'b0, 1'b1);
    rx = 1'b1;
    #(BIT_NS);
    wait_drain("after_reset_drain");
    check("total_strobes_even", n_stb_e, 7);
    check("total_strobes_odd", n_stb_o, 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
